// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302-style 3-wire RTC responder.
package ds1302_pkg;

  localparam logic [2:0] ADDR_SEC   = 3'd0;
  localparam logic [2:0] ADDR_MIN   = 3'd1;
  localparam logic [2:0] ADDR_HOUR  = 3'd2;
  localparam logic [2:0] ADDR_DATE  = 3'd3;
  localparam logic [2:0] ADDR_MONTH = 3'd4;
  localparam logic [2:0] ADDR_DAY   = 3'd5;
  localparam logic [2:0] ADDR_YEAR  = 3'd6;
  localparam logic [2:0] ADDR_CTRL  = 3'd7;
  localparam logic [4:0] ADDR_BURST = 5'd31;

  // Command byte bit positions
  localparam int unsigned CMD_START = 7;
  localparam int unsigned CMD_RAM   = 6;
  localparam int unsigned CMD_READ  = 0;

  localparam logic [7:0] RST_SEC   = 8'h80;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [7:0] RST_CTRL  = 8'h00;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} phase_e;

  // Register file, register 0 (seconds) in the least significant byte
  typedef logic [7:0][7:0] regfile_t;

  localparam regfile_t RST_REGS = {RST_CTRL, RST_YEAR, RST_DAY, RST_MONTH,
                                   RST_DATE, RST_HOUR, RST_MIN, RST_SEC};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Last BCD date of a BCD month; leap test is (10*hi + lo) mod 4 == (2*hi + lo) mod 4
  function automatic logic [7:0] month_days(input logic [7:0] month, input logic [7:0] year);
    logic leap;
    leap = ((({1'b0, year[7:4], 1'b0} + {2'b00, year[3:0]}) & 6'd3) == 6'd0);
    case (month)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // Read image selected by cmd[6:1]: clock burst gives all 8 registers
  function automatic logic [63:0] read_image(input logic [5:0] sel, input regfile_t r);
    if (sel[5])                   return '0;
    else if (sel[4:0] == ADDR_BURST) return r;
    else if (sel[4:3] == 2'b00)   return {56'd0, r[sel[2:0]]};
    else                          return '0;
  endfunction

endpackage

// File: rtl/ds1302_responder_if.sv
// 3-wire serial bus (CE, SCLK, bidirectional IO split into in/out/oe).
interface ds1302_responder_if;
  logic ce;
  logic sclk;
  logic io_in;
  logic io_out;
  logic io_oe;

  modport master (output ce, sclk, io_in, input io_out, io_oe);
  modport slave  (input ce, sclk, io_in, output io_out, io_oe);
endinterface

// File: rtl/ds1302_calendar.sv
// Timekeeping register file: prescaler, BCD time/calendar increment and write commit.
module ds1302_calendar
  import ds1302_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output regfile_t   regs
);

  regfile_t    regs_q, regs_d;
  logic [31:0] presc_q, presc_d;
  logic        tick_pend_q, tick_pend_d;
  logic        commit, tick_due, tick_now, ch, wp;

  // Next-state: commit has priority; a colliding tick is held in tick_pend for one cycle
  always_comb begin
    regs_d      = regs_q;
    presc_d     = presc_q;
    ch          = regs_q[ADDR_SEC][7];
    wp          = regs_q[ADDR_CTRL][7];
    commit      = wr_en & ((wr_addr == ADDR_CTRL) | ~wp);
    tick_due    = ~ch & (presc_q == TICK_DIV - 1);
    tick_now    = (tick_due | tick_pend_q) & ~commit & ~ch;
    tick_pend_d = (tick_due | tick_pend_q) & commit;

    if (ch || (commit && wr_addr == ADDR_SEC)) presc_d = '0;
    else if (presc_q == TICK_DIV - 1)          presc_d = '0;
    else                                       presc_d = presc_q + 32'd1;

    if (commit) begin
      case (wr_addr)
        ADDR_CTRL: regs_d[ADDR_CTRL] = {wr_data[7], 7'd0};
        ADDR_HOUR: regs_d[ADDR_HOUR] = {1'b0, wr_data[6:0]};
        default:   regs_d[wr_addr]   = wr_data;
      endcase
    end else if (tick_now) begin
      if (regs_q[ADDR_SEC][6:0] == 7'h59) begin
        regs_d[ADDR_SEC] = 8'h00;
        if (regs_q[ADDR_MIN][6:0] == 7'h59) begin
          regs_d[ADDR_MIN] = 8'h00;
          if (regs_q[ADDR_HOUR] == 8'h23) begin
            regs_d[ADDR_HOUR] = 8'h00;
            regs_d[ADDR_DAY]  = (regs_q[ADDR_DAY] >= 8'h07) ? 8'h01 : regs_q[ADDR_DAY] + 8'd1;
            if (regs_q[ADDR_DATE] >= month_days(regs_q[ADDR_MONTH], regs_q[ADDR_YEAR])) begin
              regs_d[ADDR_DATE] = 8'h01;
              if (regs_q[ADDR_MONTH] >= 8'h12) begin
                regs_d[ADDR_MONTH] = 8'h01;
                regs_d[ADDR_YEAR]  = (regs_q[ADDR_YEAR] == 8'h99) ? 8'h00 : bcd_inc(regs_q[ADDR_YEAR]);
              end else begin
                regs_d[ADDR_MONTH] = bcd_inc(regs_q[ADDR_MONTH]);
              end
            end else begin
              regs_d[ADDR_DATE] = bcd_inc(regs_q[ADDR_DATE]);
            end
          end else begin
            regs_d[ADDR_HOUR] = bcd_inc(regs_q[ADDR_HOUR]);
          end
        end else begin
          regs_d[ADDR_MIN] = bcd_inc(regs_q[ADDR_MIN]);
        end
      end else begin
        regs_d[ADDR_SEC] = bcd_inc(regs_q[ADDR_SEC]);
      end
    end
  end

  // Register file, prescaler and deferred-tick flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= RST_REGS;
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      presc_q     <= presc_d;
      tick_pend_q <= tick_pend_d;
    end
  end

  assign regs = regs_q;

endmodule

// File: rtl/ds1302_responder.sv
// DS1302-style 3-wire responder: synchronizers, serial shift/decode FSM, calendar instance.
module ds1302_responder
  import ds1302_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  ds1302_responder_if.slave         bus,
  output logic [7:0]                sec_o,
  output logic [7:0]                min_o,
  output logic [7:0]                hour_o,
  output logic                      halted
);

  // [0] first stage, [1] synchronized, [2] previous (edge detect)
  logic [2:0]  ce_sync_q, ce_sync_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  io_sync_q, io_sync_d;

  phase_e      phase_q, phase_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  bytecnt_q, bytecnt_d;
  logic [6:0]  rdcnt_q, rdcnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [63:0] snap_q, snap_d;
  logic        io_out_q, io_out_d;
  logic        io_oe_q, io_oe_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        ce_s, ce_rise, sclk_rise, sclk_fall;
  logic [7:0]  byte_in;
  logic [6:0]  rd_len;
  regfile_t    regs;

  // Synchronizer next state
  always_comb begin
    ce_sync_d   = {ce_sync_q[1:0], bus.ce};
    sclk_sync_d = {sclk_sync_q[1:0], bus.sclk};
    io_sync_d   = {io_sync_q[0], bus.io_in};
  end

  // Synchronizer flops; ce resets high so a transfer needs a fresh ce rise after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_sync_q   <= '1;
      sclk_sync_q <= '0;
      io_sync_q   <= '0;
    end else begin
      ce_sync_q   <= ce_sync_d;
      sclk_sync_q <= sclk_sync_d;
      io_sync_q   <= io_sync_d;
    end
  end

  // Transfer FSM next state: command decode, write commit, read shift-out
  always_comb begin
    ce_s      = ce_sync_q[1];
    ce_rise   = ce_sync_q[1] & ~ce_sync_q[2];
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    byte_in   = {io_sync_q[1], shreg_q};
    rd_len    = (!cmd_q[5] && cmd_q[4:0] == ADDR_BURST) ? 7'd64 : 7'd8;

    phase_d   = phase_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    rdcnt_d   = rdcnt_q;
    shreg_d   = shreg_q;
    cmd_d     = cmd_q;
    snap_d    = snap_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (!ce_s) begin
      phase_d  = IDLE;
      bitcnt_d = '0;
      io_oe_d  = 1'b0;
      io_out_d = 1'b0;
    end else begin
      case (phase_q)
        IDLE: begin
          if (ce_rise) begin
            phase_d  = CMD;
            bitcnt_d = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shreg_d  = byte_in[7:1];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              cmd_d     = byte_in[6:1];
              bytecnt_d = '0;
              rdcnt_d   = '0;
              if (!byte_in[CMD_START]) begin
                phase_d = DONE;
              end else if (byte_in[CMD_READ]) begin
                phase_d = RDATA;
                snap_d  = read_image(byte_in[6:1], regs);
              end else begin
                phase_d = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            shreg_d  = byte_in[7:1];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              bytecnt_d = bytecnt_q + 3'd1;
              phase_d   = DONE;
              if (!cmd_q[5]) begin
                if (cmd_q[4:0] == ADDR_BURST) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = bytecnt_q;
                  wr_data_d = byte_in;
                  if (bytecnt_q != 3'd7) phase_d = WDATA;
                end else if (cmd_q[4:3] == 2'b00) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cmd_q[2:0];
                  wr_data_d = byte_in;
                end
              end
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            if (rdcnt_q == rd_len) begin
              io_oe_d  = 1'b0;
              io_out_d = 1'b0;
              phase_d  = DONE;
            end else begin
              io_oe_d  = 1'b1;
              io_out_d = snap_q[0];
              snap_d   = snap_q >> 1;
              rdcnt_d  = rdcnt_q + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Transfer FSM state and registered pad/commit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= IDLE;
      bitcnt_q  <= '0;
      bytecnt_q <= '0;
      rdcnt_q   <= '0;
      shreg_q   <= '0;
      cmd_q     <= '0;
      snap_q    <= '0;
      io_out_q  <= 1'b0;
      io_oe_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      phase_q   <= phase_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
      rdcnt_q   <= rdcnt_d;
      shreg_q   <= shreg_d;
      cmd_q     <= cmd_d;
      snap_q    <= snap_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  ds1302_calendar #(.TICK_DIV(TICK_DIV)) u_calendar (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .regs    (regs)
  );

  assign bus.io_out = io_out_q;
  assign bus.io_oe  = io_oe_q;
  assign sec_o      = regs[ADDR_SEC];
  assign min_o      = regs[ADDR_MIN];
  assign hour_o     = regs[ADDR_HOUR];
  assign halted     = regs[ADDR_SEC][7];

endmodule

// File: tb/tb_ds1302_responder.sv
// Directed bench for ds1302_responder: register table plus timekeeping/abort sequences.
module tb_ds1302_responder;

  localparam int unsigned TD = 2000;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] sec_o, min_o, hour_o;
  logic halted;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ds1302_responder_if bus ();

  ds1302_responder #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .sec_o  (sec_o),
    .min_o  (min_o),
    .hour_o (hour_o),
    .halted (halted)
  );

  typedef struct {
    logic       is_rd;
    logic [7:0] cmd;
    logic [7:0] val;
    string      name;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [7:0] c, input logic [7:0] v, input string n);
    vec_t e;
    e.is_rd = r; e.cmd = c; e.val = v; e.name = n;
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (HP) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    bus.io_in = b;
    half();
    bus.sclk = 1'b1;
    half();
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
  endtask

  task automatic start();
    bus.ce = 1'b1;
    half();
  endtask

  task automatic stop();
    half();
    bus.ce = 1'b0;
    bus.io_in = 1'b0;
    repeat (4) half();
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [7:0] d);
    start(); send_byte(cmd); send_byte(d); stop();
  endtask

  task automatic burst_wr(input logic [63:0] d);
    start();
    send_byte(8'hBE);
    for (int i = 0; i < 8; i++) send_byte(d[i*8 +: 8]);
    stop();
  endtask

  task automatic rd(input logic [7:0] cmd, input int nbits, input string name, output logic [63:0] d);
    int oe_bad;
    d = '0;
    oe_bad = 0;
    start();
    send_byte(cmd);
    for (int i = 0; i < nbits; i++) begin
      half();
      d[i] = bus.io_out;
      if (bus.io_oe !== 1'b1) oe_bad++;
      bus.sclk = 1'b1;
      half();
      bus.sclk = 1'b0;
    end
    half();
    chk({name, "_oe_high"}, oe_bad, 0);
    chk({name, "_oe_drop"}, bus.io_oe, 1'b0);
    stop();
  endtask

  task automatic wait_sec(input logic [7:0] v, input int budget, output logic found, output int unsigned t);
    found = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (sec_o == v) begin
        found = 1'b1;
        t = cyc;
      end
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [7:0] pat;
    logic found;
    int unsigned t0, t1;

    bus.ce = 1'b0; bus.sclk = 1'b0; bus.io_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_sec", sec_o, 8'h80);
    chk("rst_min", min_o, 8'h00);
    chk("rst_hour", hour_o, 8'h00);
    chk("rst_halted", halted, 1'b1);
    chk("rst_io_oe", bus.io_oe, 1'b0);
    chk("rst_io_out", bus.io_out, 1'b0);

    // Register access table (clock halted throughout)
    add(1, 8'h81, 8'h80, "rd_sec");
    add(1, 8'h83, 8'h00, "rd_min");
    add(1, 8'h85, 8'h00, "rd_hour");
    add(1, 8'h87, 8'h01, "rd_date");
    add(1, 8'h89, 8'h01, "rd_month");
    add(1, 8'h8B, 8'h01, "rd_day");
    add(1, 8'h8D, 8'h00, "rd_year");
    add(1, 8'h8F, 8'h00, "rd_ctrl");
    add(0, 8'h82, 8'h42, "");
    add(1, 8'h83, 8'h42, "wr_min");
    add(0, 8'h8E, 8'h80, "");
    add(1, 8'h8F, 8'h80, "wp_set");
    add(0, 8'h82, 8'h15, "");
    add(1, 8'h83, 8'h42, "wp_blocks_min");
    add(0, 8'h8E, 8'h00, "");
    add(1, 8'h8F, 8'h00, "wp_clear");
    add(0, 8'h82, 8'h15, "");
    add(1, 8'h83, 8'h15, "wr_min_after_wp");
    add(0, 8'h8E, 8'h7F, "");
    add(1, 8'h8F, 8'h00, "ctrl_bit7_only");
    add(0, 8'hC0, 8'h55, "");
    add(1, 8'hC1, 8'h00, "ram_reads_zero");
    add(1, 8'h91, 8'h00, "undef_reads_zero");
    add(0, 8'h84, 8'hA3, "");
    add(1, 8'h85, 8'h23, "hour_bit7_cleared");
    add(0, 8'h02, 8'h99, "");
    add(1, 8'h83, 8'h15, "cmd7_zero_ignored");
    add(0, 8'h8C, 8'h99, "");
    add(1, 8'h8D, 8'h99, "wr_year");

    foreach (vt[k]) begin
      if (vt[k].is_rd) begin
        rd(vt[k].cmd, 8, vt[k].name, d);
        chk(vt[k].name, d[7:0], vt[k].val);
      end else begin
        wr(vt[k].cmd, vt[k].val);
      end
    end

    // Start the clock at 30 s and time the first tick
    wr(8'h8E, 8'h00);
    fork
      wr(8'h80, 8'h30);
      wait_sec(8'h30, 1000, found, t0);
    join
    chk("s1_sec30_seen", found, 1'b1);
    chk("s1_running", halted, 1'b0);
    wait_sec(8'h31, 3 * TD, found, t1);
    chk("s1_sec31_seen", found, 1'b1);
    chk("s1_tick_period", t1 - t0, TD);
    wr(8'h80, 8'h80);
    chk("s1_halted_again", halted, 1'b1);

    // Single read of seconds, bit by bit
    wr(8'h80, 8'h45);
    rd(8'h81, 8, "s3", d);
    pat = 8'b0100_0101;
    for (int i = 0; i < 8; i++) chk($sformatf("s3_bit%0d", i), d[i], pat[i]);
    wr(8'h80, 8'h80);

    // Midnight rollover on 28 Feb, non-leap then leap year
    burst_wr(64'h00_23_03_02_28_23_59_59);
    wait_sec(8'h00, 3 * TD, found, t0);
    chk("s2_tick_seen", found, 1'b1);
    chk("s2_min", min_o, 8'h00);
    chk("s2_hour", hour_o, 8'h00);
    rd(8'hBF, 64, "s2_burst", d);
    chk("s2_calendar", d, 64'h00_23_04_03_01_00_00_00);
    wr(8'h80, 8'h80);

    burst_wr(64'h00_24_03_02_28_23_59_59);
    wait_sec(8'h00, 3 * TD, found, t0);
    chk("s2l_tick_seen", found, 1'b1);
    rd(8'hBF, 64, "s2l_burst", d);
    chk("s2l_calendar", d, 64'h00_24_04_02_29_00_00_00);
    wr(8'h80, 8'h80);

    // Burst write/read round trip, halted then with a tick during the read
    burst_wr(64'h00_77_02_06_15_12_34_95);
    rd(8'hBF, 64, "s4_halted", d);
    chk("s4_roundtrip", d, 64'h00_77_02_06_15_12_34_95);
    burst_wr(64'h00_77_02_06_15_12_34_10);
    repeat (550) @(negedge clk);
    rd(8'hBF, 64, "s4_running", d);
    chk("s4_snapshot", d, 64'h00_77_02_06_15_12_34_10);
    chk("s4_ticked_during_read", sec_o, 8'h11);
    wr(8'h80, 8'h80);

    // Write aborted after 4 data bits
    start();
    send_byte(8'h82);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    stop();
    chk("s6_min_unchanged", min_o, 8'h34);
    chk("s6_io_oe", bus.io_oe, 1'b0);
    wr(8'h82, 8'h37);
    chk("s6_next_write", min_o, 8'h37);

    // ce falls in the middle of a read
    start();
    send_byte(8'h83);
    half();
    chk("rd_abort_oe_before", bus.io_oe, 1'b1);
    bus.sclk = 1'b1; half(); bus.sclk = 1'b0; half();
    bus.ce = 1'b0;
    repeat (6) @(negedge clk);
    chk("rd_abort_oe_after", bus.io_oe, 1'b0);
    repeat (4) half();

    // Reset mid-transfer; further clocks under the same ce must be ignored
    start();
    send_byte(8'h82);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_min", min_o, 8'h00);
    chk("rst_mid_sec", sec_o, 8'h80);
    chk("rst_mid_oe", bus.io_oe, 1'b0);
    send_byte(8'h82);
    send_byte(8'h55);
    stop();
    chk("rst_abort_ignored", min_o, 8'h00);
    wr(8'h82, 8'h21);
    chk("rst_fresh_transfer", min_o, 8'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds1302_responder.md
DS1302_RESPONDER -- requirements
Module: ds1302_responder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per 1 s timekeeping tick.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-004 SHALL have port ce, input, 1, 3-wire chip enable (active-high, frames a transfer).
REQ-005 SHALL have port sclk, input, 1, 3-wire serial clock.
REQ-006 SHALL have port io_in, input, 1, serial data from the pad.
REQ-007 SHALL have port io_out, output, 1, serial data to the pad.
REQ-008 SHALL have port io_oe, output, 1, pad drive enable (1 = responder drives).
REQ-009 SHALL have port sec_o, min_o, hour_o, output, 8 each, live BCD time registers for monitoring.
REQ-010 SHALL have port halted, output, 1, copy of CH (seconds bit 7).

Function
REQ-011 SHALL pass ce, sclk and io_in through 2-flop synchronizers; it SHALL detect sclk edges in the clk domain; sclk high/low phases are at least 4 clk.
REQ-012 SHALL shift bits LSB first: command byte on 8 rising sclk edges; cmd[7] = 1 is required, cmd[6] = 1 selects RAM, cmd[5:1] = address, cmd[0] = 1 selects read.
REQ-013 SHALL ignore the transfer until ce falls if cmd[7] = 0.
REQ-014 SHALL implement registers 0..7: sec, min, hour, date, month, day, year, control (WP = bit 7); address 31 SHALL select clock burst.
REQ-015 On a write, SHALL take the next 8 rising edges as the data byte and commit it on the 8th edge; a burst write SHALL commit bytes 0..7 in order.
REQ-016 SHALL ignore writes to addresses 0..6 when WP = 1; writes to control SHALL always commit, storing bit 7 only.
REQ-017 SHALL ignore writes with cmd[6] = 1, and reads with cmd[6] = 1 SHALL return 0x00; undefined addresses SHALL read 0x00, and writes to them SHALL be ignored.
REQ-018 On a read, SHALL snapshot all 8 registers at command decode (the 8th rising edge).
REQ-019 On a read, SHALL assert io_oe and drive data bit 0 within 3 clk of the falling edge that follows the 8th command bit, then drive each next bit on each following falling edge.
REQ-020 On a single read, SHALL drop io_oe on the falling edge after data bit 7; on a burst read, SHALL continue through 64 bits and then drop io_oe.
REQ-021 SHALL, while ce is low, hold io_oe = 0 and clear the bit counter; a partial byte at ce fall SHALL be discarded; ce fall mid-read SHALL drop io_oe within 3 clk of the synchronized edge.
REQ-022 SHALL count a prescaler to TICK_DIV-1 and tick when CH = 0; while CH = 1, the prescaler SHALL hold at 0.
REQ-023 SHALL reset the prescaler to 0 on a committed seconds write.
REQ-024 On a tick, SHALL increment in BCD with these rollovers: sec 59->00 carries to min; min 59->00 carries to hour; hour 23->00 (24 h only, bit 7 stored as 0) carries to date and day.
REQ-025 SHALL roll day 7->1.
REQ-026 SHALL roll date at month end (30/31 days; Feb 28, or 29 when year mod 4 = 0) to 01 and carry to month.
REQ-027 SHALL roll month 12->01 and carry to year; year SHALL roll 99->00.
REQ-028 SHALL, when a commit and a tick occur in the same clk cycle, apply the commit and defer the tick by one cycle.

Reset
REQ-029 Reset SHALL set: sec 0x80 (halted), min 0x00, hour 0x00, date 0x01, month 0x01, day 0x01, year 0x00, control 0x00, prescaler 0, shift state idle, io_oe 0, io_out 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer; the responder SHALL wait for a fresh ce rise.

Structure
REQ-031 Package ds1302_pkg SHALL hold register addresses, the burst address 31, command bit positions, reset values and the transfer-phase enum (IDLE, CMD, WDATA, RDATA, DONE).
REQ-032 BCD time/calendar increment logic SHALL be sub-module ds1302_calendar; serial shifting and decode SHALL stay in ds1302_responder.

Verification
REQ-033 Scenario 1: write 0x8E/0x00, then 0x80/0x30 -> sec_o = 0x30, halted = 0; after TICK_DIV clk, sec_o = 0x31.
REQ-034 Scenario 2: preset 23:59:59 on 28-Feb year 0x23, then 1 tick -> 00:00:00, date 0x01, month 0x03, day advanced; with year 0x24 -> date 0x29, month 0x02.
REQ-035 Scenario 3: single read 0x81 after sec = 0x45 -> io pattern 1,0,1,0,0,0,1,0 (LSB first); io_oe low after the 8th falling edge.
REQ-036 Scenario 4: burst write 0xBE with 8 bytes, then burst read 0xBF -> identical 64 bits returned; the snapshot does not change if a tick occurs mid-read.
REQ-037 Scenario 5: set WP = 1 via 0x8E/0x80, then write 0x82/0x15 -> min_o unchanged; a write of 0x00 to control still clears WP.
REQ-038 Scenario 6: drop ce after 4 data bits of a write -> no register change; io_oe = 0; the next full transfer succeeds.
